// File: rtl/cavlc_bit_packer_pkg.sv
// Shared constants and FSM encoding for the CAVLC bit packer and its helpers.
package cavlc_bit_packer_pkg;
    localparam int PACK_ACC_W = 64;
    localparam int PACK_OUT_W = 32;
    localparam int PACK_IN_W  = 31;

    typedef enum logic [1:0] {
        PK_RUN   = 2'd0,
        PK_FLUSH = 2'd1,
        PK_DONE  = 2'd2
    } pkState_t;
endpackage

// File: rtl/cavlc_bit_mask_shift.sv
// Masks an MSB-aligned code chunk to its length and places it into the 64-bit
// accumulator lane right after the bits already held.
module cavlc_bit_mask_shift
    import cavlc_bit_packer_pkg::*;
(
    input  logic [PACK_IN_W-1:0]  inBits,
    input  logic [4:0]            inLen,
    input  logic [6:0]            fill,
    output logic [PACK_ACC_W-1:0] lane
);
    logic [PACK_IN_W-1:0] keepMask;
    logic [PACK_IN_W-1:0] maskedBits;

    // Bit gi survives only if it lies within the top inLen positions.
    generate
        for (genvar gi = 0; gi < PACK_IN_W; gi++) begin : g_mask
            assign keepMask[gi] = ({1'b0, inLen} + 6'(gi)) >= 6'(PACK_IN_W);
        end
    endgenerate

    assign maskedBits = inBits & keepMask;
    assign lane       = {maskedBits, {(PACK_ACC_W - PACK_IN_W){1'b0}}} >> fill;
endmodule

// File: rtl/cavlc_bit_packer.sv
// Concatenates variable-length code chunks into 32-bit big-endian stream words,
// with flush draining. Optional bit counter: define CAVLC_PACKER_BITCNT_EN.
module cavlc_bit_packer
    import cavlc_bit_packer_pkg::*;
#(
    parameter int IN_W  = 31,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_bits,
    input  logic [4:0]       in_len,
    input  logic             flush_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [5:0]       out_nbits,
    output logic             out_last,
    output logic             flush_done
`ifdef CAVLC_PACKER_BITCNT_EN
    ,
    output logic [23:0]      bit_cnt
`endif
);
    pkState_t              stateReg;
    logic [PACK_ACC_W-1:0] accReg, accNext, accShifted, lane;
    logic [6:0]            fillReg, fillNext, fillAfterEmit;
    logic                  emit, accept;

    assign in_ready   = (stateReg == PK_RUN) && (fillReg <= 7'd32);
    assign out_valid  = (fillReg >= 7'd32) || ((stateReg == PK_FLUSH) && (fillReg != 7'd0));
    assign out_data   = accReg[PACK_ACC_W-1 -: PACK_OUT_W];
    assign out_nbits  = (fillReg >= 7'd32) ? 6'd32 : fillReg[5:0];
    assign out_last   = (stateReg == PK_FLUSH) && (fillReg <= 7'd32);
    assign flush_done = (stateReg == PK_DONE);

    assign emit   = out_valid && out_ready;
    assign accept = in_valid && in_ready;

    cavlc_bit_mask_shift u_maskShift (
        .inBits (in_bits),
        .inLen  (in_len),
        .fill   (fillAfterEmit),
        .lane   (lane)
    );

    // Emit is retired first so the new chunk lands right behind the surviving bits.
    always_comb begin
        accShifted    = accReg;
        fillAfterEmit = fillReg;
        if (emit) begin
            accShifted    = accReg << PACK_OUT_W;
            fillAfterEmit = (fillReg > 7'd32) ? (fillReg - 7'd32) : 7'd0;
        end
        accNext  = accShifted;
        fillNext = fillAfterEmit;
        if (accept) begin
            accNext  = accShifted | lane;
            fillNext = fillAfterEmit + {2'b00, in_len};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= PK_RUN;
            accReg   <= '0;
            fillReg  <= '0;
        end else begin
            unique case (stateReg)
                PK_RUN: begin
                    accReg  <= accNext;
                    fillReg <= fillNext;
                    if (flush_req)
                        stateReg <= PK_FLUSH;
                end
                PK_FLUSH: begin
                    accReg  <= accNext;
                    fillReg <= fillNext;
                    if ((fillReg == 7'd0) || (emit && out_last))
                        stateReg <= PK_DONE;
                end
                PK_DONE: begin
                    accReg   <= '0;
                    fillReg  <= '0;
                    stateReg <= PK_RUN;
                end
                default: stateReg <= PK_RUN;
            endcase
        end
    end

`ifdef CAVLC_PACKER_BITCNT_EN
    logic [23:0] bitCntReg;
    logic [24:0] bitCntSum;

    assign bitCntSum = {1'b0, bitCntReg} + {20'd0, in_len};
    assign bit_cnt   = bitCntReg;

    always_ff @(posedge clk) begin
        if (rst || (stateReg == PK_DONE))
            bitCntReg <= '0;
        else if (accept)
            bitCntReg <= bitCntSum[24] ? 24'hFF_FFFF : bitCntSum[23:0];
    end
`endif
endmodule
